// File: rtl/pipeline_fifo_pkg.sv
// Shared constants and helpers for the pipeline output FIFO.
// Combinational only (no latency, no flow control of its own).
package pipeline_fifo_pkg;

  localparam int          DROP_CNT_W   = 16;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage, one synchronous write port and one asynchronous read port; not reset.
// Write lands at the clock edge, read is combinational; no backpressure (the caller gates wr_en).
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipeline_output_fifo.sv
// FWFT buffer behind a valid-only pipeline: a push is visible one cycle later, with no bypass.
// The producer gets almost_full as its throttle; pushes into a full FIFO with no pop are dropped and counted.
module pipeline_output_fifo
  import pipeline_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [DROP_CNT_W-1:0]    drop_count,
  input  logic                     clear_overflow
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - SLACK);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Flags decode from the registered count only, so no input reaches an output combinationally.
  assign full        = (count == FULL_CNT);
  assign out_valid   = (count != '0);
  assign almost_full = (count >= AF_CNT);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop coinciding with a clear wins and restarts the count at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)                  drop_count <= DROP_CNT_W'(1);
      else if (drop_count != DROP_CNT_MAX) drop_count <= drop_count + DROP_CNT_W'(1);
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_pipeline_output_fifo.sv
// Randomized and directed bench for pipeline_output_fifo against a queue-based reference model.
module tb_pipeline_output_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int SLACK = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        count;
  logic              almost_full;
  logic              overflow;
  logic [15:0]       drop_count;
  logic              clear_overflow = 1'b0;

  pipeline_output_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SLACK (SLACK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: queue contents, sticky flag and saturating drop count.
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  int          m_dcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid",   32'(out_valid),   32'(mq.size() != 0));
    chk("count",       32'(count),       32'(mq.size()));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - SLACK));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("drop_count",  32'(drop_count),  32'(m_dcnt));
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
  endtask

  // Called just after a falling edge: check, drive, advance model, wait one cycle.
  task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit clr);
    bit do_pop;
    check_outputs();
    in_valid       = iv;
    in_data        = d;
    out_ready      = ordy;
    clear_overflow = clr;
    do_pop = (mq.size() != 0) && ordy;
    if (do_pop) void'(mq.pop_front());
    if (iv && (mq.size() < DEPTH)) begin
      mq.push_back(d);
    end else if (iv) begin
      m_ovf  = 1'b1;
      m_dcnt = clr ? 1 : ((m_dcnt < 65535) ? m_dcnt + 1 : 65535);
    end
    if (clr && !(iv && !do_pop && mq.size() == DEPTH && m_dcnt != 0 && m_ovf && iv && (mq.size() == DEPTH) && !do_pop)) begin
      // clear applies only when no drop happened this cycle
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Clear is modelled separately so the drop-wins rule stays readable.
  task automatic cyc(input bit iv, input logic [31:0] d, input bit ordy, input bit clr);
    bit will_drop;
    will_drop = iv && (mq.size() == DEPTH) && !ordy;
    if (clr && !will_drop) begin
      check_outputs();
      in_valid = iv; in_data = d; out_ready = ordy; clear_overflow = clr;
      if ((mq.size() != 0) && ordy) void'(mq.pop_front());
      if (iv) mq.push_back(d);
      m_ovf  = 1'b0;
      m_dcnt = 0;
      @(posedge clk);
      @(negedge clk);
    end else begin
      step(iv, d, ordy, clr);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Idle after reset
    cyc(0, 0, 0, 0);

    // Three pushes held, then drain in order
    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h22, 0, 0);
    cyc(1, 32'h33, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

    // Fill, drop one, then push+pop while full
    for (int i = 0; i < 4; i++) cyc(1, 32'hC0 + 32'(i), 0, 0);
    cyc(1, 32'hAA, 0, 0);
    cyc(1, 32'hBB, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

    // Clear the overflow state before the streaming phase
    cyc(0, 0, 0, 1);

    // Streaming push+pop across pointer wrap
    cyc(1, 32'd0, 0, 0);
    for (int i = 1; i < 10; i++) cyc(1, 32'(i), 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Drop coinciding with clear, then clear alone
    for (int i = 0; i < 4; i++) cyc(1, 32'hD0 + 32'(i), 0, 0);
    cyc(1, 32'hEE, 0, 0);
    cyc(1, 32'hEF, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) < 6), $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);

    // Async reset mid-cycle with three entries stored
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    cyc(1, 32'h71, 0, 0);
    cyc(1, 32'h72, 0, 0);
    cyc(1, 32'h73, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_dcnt = 0;
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 32'h5A, 0, 0);
    cyc(0, 0, 0, 0);
    chk("first_after_reset", out_data, 32'h5A);

    // Saturation of the drop counter
    for (int i = 0; i < 3; i++) cyc(1, 32'hF0 + 32'(i), 0, 0);
    for (int i = 0; i < 70000; i++) cyc(1, $urandom, 0, 0);
    check_outputs();
    chk("drop_sat", 32'(drop_count), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
